alu_control_seq: RTL
====================

ALU_CONTROL_SEQ -- requirements
Module: alu_control_seq

Interface
REQ-001 Parameter CTW, 5, width of control_type.
REQ-002 Parameter MULT_CYCLES, 32, cycles mult_op is held (legal range 1..255).
REQ-003 Parameter DIV_CYCLES, 32, cycles div_op is held (legal range 1..255).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous abort of any in-flight operation.
REQ-007 req_valid  input  1  control_type is valid this cycle.
REQ-008 req_ready  output  1  block accepts a request this cycle.
REQ-009 control_type  input  CTW  operation code.
REQ-010 div_by_zero  input  1  divisor-is-zero flag from datapath, sampled at acceptance.
REQ-011 cond_type  output  2; alu_op  output  3; src_out  output  3; store_md  output  2.
REQ-012 or_op, overflow_op, alu_out_save, mult_op, div_op  output  1 each.
REQ-013 busy, done, exc_div0, illegal_op  output  1 each.

Function
REQ-014 States SHALL be IDLE, EXEC, MD_RUN, MD_DONE.
REQ-015 req_ready SHALL equal (state==IDLE) && !flush && !reset; a request is accepted when req_valid && req_ready.
REQ-016 Decode: codes 0-7 alu_op=code[2:0], src_out=3 (code 7: src_out=2); overflow_op=1 for codes 1,2,4 only.
REQ-017 Decode: 8 or_op=1,src_out=4; 11 alu_op=1,src_out=3,no overflow; 12 src_out=1; 13 src_out=0; 18 src_out=6.
REQ-018 Decode: 14-17 cond_type=code-14, alu_out_save=0; alu_out_save=1 for codes 0-8, 11-13, 18.
REQ-019 Decode: 9 = divide, 10 = multiply; codes 19..2^CTW-1 are illegal.
REQ-020 Single-cycle codes: IDLE -> EXEC; decoded outputs and done SHALL be high for exactly the EXEC cycle (latency 1), then IDLE.
REQ-021 Illegal code: IDLE -> EXEC; illegal_op and done pulse one cycle, all decode outputs 0.
REQ-022 Multiply: IDLE -> MD_RUN, counter loaded MULT_CYCLES-1; mult_op=1 every MD_RUN cycle; at counter 0 -> MD_DONE.
REQ-023 Divide: as REQ-022 with DIV_CYCLES and div_op.
REQ-024 MD_DONE SHALL last one cycle: store_md=01 (div) or 10 (mult), done=1; then IDLE; total latency = N+1 cycles.
REQ-025 Divide with div_by_zero=1 at acceptance SHALL go to EXEC: exc_div0=1, done=1, div_op=0, store_md=00.
REQ-026 busy SHALL be 1 in EXEC, MD_RUN, MD_DONE.
REQ-027 flush in any state SHALL force IDLE next edge with all outputs 0 and no done pulse; flush with req_valid in IDLE accepts nothing.
REQ-028 All outputs except req_ready SHALL be registered and 0 whenever not driven by REQ-020..REQ-025.
REQ-029 Counter width SHALL be 8 bits; no wrap occurs within the legal parameter range.

Reset
REQ-030 reset SHALL asynchronously force state IDLE, counter 0, all registered outputs 0.
REQ-031 First request SHALL be accepted on the first edge after reset deasserts.

Structure
REQ-032 Opcode localparams, state enum typedef and decode-record struct SHALL live in package alu_ctrl_pkg.
REQ-033 Combinational decode SHALL be sub-module alu_ctrl_decode (control_type -> decode record, illegal flag); sequencer is top level.

Verification
REQ-034 Code 1 accepted at cycle 0 -> cycle 1: alu_op=001, overflow_op=1, src_out=011, alu_out_save=1, done=1; cycle 2 all 0.
REQ-035 Code 10, MULT_CYCLES=4 -> mult_op high cycles 1-4, cycle 5 store_md=10 and done=1, req_ready=1 in cycle 6.
REQ-036 Code 9 with div_by_zero=1 -> cycle 1 exc_div0=1, done=1, div_op never asserted.
REQ-037 Code 9, DIV_CYCLES=32, flush at cycle 10 -> cycle 11 IDLE, all outputs 0, no done, no store_md.
REQ-038 Code 25 -> cycle 1 illegal_op=1, done=1, alu_out_save=0; reset asserted mid-MD_RUN -> outputs 0 immediately, no clock edge required.
REQ-039 Back-to-back: codes 15 then 8 with req_valid held -> cond_type=01 cycle 1, or_op=1 src_out=100 cycle 3.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared opcodes, state encoding and decode/output records for the ALU control sequencer.
package alu_ctrl_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  localparam logic [31:0] OP_ALU_LAST    = 32'd7;
  localparam logic [31:0] OP_OR          = 32'd8;
  localparam logic [31:0] OP_DIV         = 32'd9;
  localparam logic [31:0] OP_MULT        = 32'd10;
  localparam logic [31:0] OP_ALU1_NOV    = 32'd11;
  localparam logic [31:0] OP_SRC1        = 32'd12;
  localparam logic [31:0] OP_SRC0        = 32'd13;
  localparam logic [31:0] OP_COND_FIRST  = 32'd14;
  localparam logic [31:0] OP_COND_LAST   = 32'd17;
  localparam logic [31:0] OP_SRC6        = 32'd18;

  localparam logic [1:0] SMD_NONE = 2'b00;
  localparam logic [1:0] SMD_DIV  = 2'b01;
  localparam logic [1:0] SMD_MULT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_MD_RUN  = 2'd2,
    ST_MD_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0] cond_type;
    logic [2:0] alu_op;
    logic [2:0] src_out;
    logic       or_op;
    logic       overflow_op;
    logic       alu_out_save;
    logic       is_mult;
    logic       is_div;
  } dec_t;

  typedef struct packed {
    logic [1:0] cond_type;
    logic [2:0] alu_op;
    logic [2:0] src_out;
    logic [1:0] store_md;
    logic       or_op;
    logic       overflow_op;
    logic       alu_out_save;
    logic       mult_op;
    logic       div_op;
    logic       busy;
    logic       done;
    logic       exc_div0;
    logic       illegal_op;
  } out_t;

  // Counter is loaded with N-1 so that the op signal is held for exactly N cycles.
  function automatic logic [CNT_W-1:0] md_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational opcode decode: control_type to decode record plus illegal flag.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int CTW = 5
) (
  input  logic [CTW-1:0] control_type,
  output dec_t           dec,
  output logic           illegal
);

  logic [31:0] code;

  assign code = 32'(control_type);

  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    if (code <= OP_ALU_LAST) begin
      dec.alu_op       = code[2:0];
      dec.src_out      = (code == OP_ALU_LAST) ? 3'd2 : 3'd3;
      dec.overflow_op  = (code == 32'd1) || (code == 32'd2) || (code == 32'd4);
      dec.alu_out_save = 1'b1;
    end else if ((code >= OP_COND_FIRST) && (code <= OP_COND_LAST)) begin
      dec.cond_type = 2'(code - OP_COND_FIRST);
    end else begin
      case (code)
        OP_OR: begin
          dec.or_op        = 1'b1;
          dec.src_out      = 3'd4;
          dec.alu_out_save = 1'b1;
        end
        OP_DIV:  dec.is_div  = 1'b1;
        OP_MULT: dec.is_mult = 1'b1;
        OP_ALU1_NOV: begin
          dec.alu_op       = 3'd1;
          dec.src_out      = 3'd3;
          dec.alu_out_save = 1'b1;
        end
        OP_SRC1: begin
          dec.src_out      = 3'd1;
          dec.alu_out_save = 1'b1;
        end
        OP_SRC0: begin
          dec.src_out      = 3'd0;
          dec.alu_out_save = 1'b1;
        end
        OP_SRC6: begin
          dec.src_out      = 3'd6;
          dec.alu_out_save = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control sequencer: accepts one opcode at a time, pulses single-cycle controls
// or holds mult/div for a fixed cycle count, then reports done.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for a request, req_ready high unless flush/reset
// ST_EXEC    | one-cycle result: decoded controls, illegal_op or exc_div0
// ST_MD_RUN  | mult_op/div_op held while the down-counter runs to zero
// ST_MD_DONE | one-cycle completion with store_md selecting the md result
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int CTW         = 5,
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [CTW-1:0] control_type,
  input  logic           div_by_zero,
  output logic [1:0]     cond_type,
  output logic [2:0]     alu_op,
  output logic [2:0]     src_out,
  output logic [1:0]     store_md,
  output logic           or_op,
  output logic           overflow_op,
  output logic           alu_out_save,
  output logic           mult_op,
  output logic           div_op,
  output logic           busy,
  output logic           done,
  output logic           exc_div0,
  output logic           illegal_op
);

  localparam logic [CNT_W-1:0] MULT_LOAD = md_load(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = md_load(DIV_CYCLES);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             md_div, md_div_nxt;
  out_t             out_q, out_nxt;
  dec_t             dec;
  logic             illegal;
  logic             accept;

  alu_ctrl_decode #(
    .CTW(CTW)
  ) u_decode (
    .control_type(control_type),
    .dec         (dec),
    .illegal     (illegal)
  );

  assign req_ready = (state == ST_IDLE) && !flush && !reset;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      md_div <= 1'b0;
      out_q  <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      md_div <= md_div_nxt;
      out_q  <= out_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    md_div_nxt = md_div;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          // Divide-by-zero is reported immediately instead of running the divider.
          if ((dec.is_mult || dec.is_div) && !(dec.is_div && div_by_zero)) begin
            state_nxt  = ST_MD_RUN;
            md_div_nxt = dec.is_div;
            cnt_nxt    = dec.is_div ? DIV_LOAD : MULT_LOAD;
          end else begin
            state_nxt = ST_EXEC;
          end
        end
      end
      ST_EXEC: state_nxt = ST_IDLE;
      ST_MD_RUN: begin
        if (cnt == '0) state_nxt = ST_MD_DONE;
        else           cnt_nxt   = cnt - CNT_ONE;
      end
      ST_MD_DONE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      state_nxt  = ST_IDLE;
      cnt_nxt    = '0;
      md_div_nxt = 1'b0;
    end
  end

  // Outputs are computed for the state being entered so they register alongside it.
  always_comb begin
    out_nxt = '0;
    case (state_nxt)
      ST_EXEC: begin
        out_nxt.busy = 1'b1;
        out_nxt.done = 1'b1;
        if (illegal) begin
          out_nxt.illegal_op = 1'b1;
        end else if (dec.is_div) begin
          out_nxt.exc_div0 = 1'b1;
        end else begin
          out_nxt.cond_type    = dec.cond_type;
          out_nxt.alu_op       = dec.alu_op;
          out_nxt.src_out      = dec.src_out;
          out_nxt.or_op        = dec.or_op;
          out_nxt.overflow_op  = dec.overflow_op;
          out_nxt.alu_out_save = dec.alu_out_save;
        end
      end
      ST_MD_RUN: begin
        out_nxt.busy    = 1'b1;
        out_nxt.mult_op = !md_div_nxt;
        out_nxt.div_op  = md_div_nxt;
      end
      ST_MD_DONE: begin
        out_nxt.busy     = 1'b1;
        out_nxt.done     = 1'b1;
        out_nxt.store_md = md_div ? SMD_DIV : SMD_MULT;
      end
      default: out_nxt = '0;
    endcase
  end

  assign cond_type    = out_q.cond_type;
  assign alu_op       = out_q.alu_op;
  assign src_out      = out_q.src_out;
  assign store_md     = out_q.store_md;
  assign or_op        = out_q.or_op;
  assign overflow_op  = out_q.overflow_op;
  assign alu_out_save = out_q.alu_out_save;
  assign mult_op      = out_q.mult_op;
  assign div_op       = out_q.div_op;
  assign busy         = out_q.busy;
  assign done         = out_q.done;
  assign exc_div0     = out_q.exc_div0;
  assign illegal_op   = out_q.illegal_op;

endmodule
